ecc_sector_engine: RTL

- Parametrised single-engine successor to the split encode/decode ECC wrapper.
- Computes NAND-style Hamming line/column parity over one sector of SECTOR_WORDS words of DATA_W bits.
- Encode mode: emits the ECC code.
- Decode mode: takes the stored code after the data, classifies the sector, and locates a single-bit error.
- Sits between the NAND controller datapath and the page buffer; one sector per start/done transaction.

---
 rtl/ecc_sector_pkg.sv | 23 ++
 rtl/ecc_parity_acc.sv | 51 +++++
 rtl/ecc_sector_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ecc_sector_pkg.sv
// Shared definitions for the sector ECC engine: status codes, FSM states
// and the code-width helper used to size the ECC ports.
package ecc_sector_pkg;

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_UNCORR  = 2'b10;
    localparam logic [1:0] ST_ECCERR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_ECCIN  = 3'd2,
        S_FIN    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    // One odd/even pair per line-index bit and per column-index bit.
    function automatic int ecc_width(input int data_w, input int sector_words);
        return 2 * ($clog2(sector_words) + $clog2(data_w));
    endfunction

endpackage

// File: rtl/ecc_parity_acc.sv
// Running parity accumulators for one sector: the column XOR of every
// accepted word and the odd/even line parities indexed by word number.
module ecc_parity_acc #(
    parameter  int DATA_W       = 32,
    parameter  int SECTOR_WORDS = 128,
    localparam int LW           = $clog2(SECTOR_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              beat,
    input  logic [DATA_W-1:0] data,
    input  logic [LW-1:0]     word_idx,
    output logic [DATA_W-1:0] colacc,
    output logic [LW-1:0]     line_odd,
    output logic [LW-1:0]     line_even
);

    logic              wp_s;
    logic [LW-1:0]     line_odd_nxt_s;
    logic [LW-1:0]     line_even_nxt_s;

    function automatic logic word_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Fold the word parity into the odd or even slot of every index bit.
    always_comb begin
        wp_s            = word_parity(data);
        line_odd_nxt_s  = line_odd  ^ (word_idx  & {LW{wp_s}});
        line_even_nxt_s = line_even ^ (~word_idx & {LW{wp_s}});
    end

    // Accumulator registers: cleared on a new sector, updated per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colacc    <= '0;
            line_odd  <= '0;
            line_even <= '0;
        end else if (clr) begin
            colacc    <= '0;
            line_odd  <= '0;
            line_even <= '0;
        end else if (beat) begin
            colacc    <= colacc ^ data;
            line_odd  <= line_odd_nxt_s;
            line_even <= line_even_nxt_s;
        end
    end

endmodule

// File: rtl/ecc_sector_engine.sv
// Single-engine NAND Hamming ECC over one sector: encode emits the code,
// decode compares against the stored code beat and locates a 1-bit error.
// Optional error statistics counters: define ECC_SECTOR_STATS_EN.
module ecc_sector_engine
    import ecc_sector_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int SECTOR_WORDS = 128,
    localparam int CW           = $clog2(DATA_W),
    localparam int LW           = $clog2(SECTOR_WORDS),
    localparam int ECC_W        = ecc_width(DATA_W, SECTOR_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ECC_W-1:0]  ecc_out,
    output logic              done,
    output logic [1:0]        status,
`ifdef ECC_SECTOR_STATS_EN
    input  logic              cnt_clr,
    output logic [15:0]       cnt_corr,
    output logic [15:0]       cnt_uncorr,
`endif
    output logic [LW-1:0]     err_word,
    output logic [CW-1:0]     err_bit
);

    localparam logic [LW-1:0] LAST_WORD = LW'(SECTOR_WORDS - 1);
    localparam logic [LW-1:0] ONE_WORD  = LW'(1);

    state_t            state_r;
    logic              mode_r;
    logic [LW-1:0]     word_r;
    logic [ECC_W-1:0]  stored_r;

    logic              beat_s;
    logic              acc_clr_s;
    logic              acc_beat_s;
    logic [DATA_W-1:0] colacc_s;
    logic [LW-1:0]     line_odd_s;
    logic [LW-1:0]     line_even_s;
    logic [CW-1:0]     col_odd_s;
    logic [CW-1:0]     col_even_s;
    logic [ECC_W-1:0]  ecc_s;
    logic [ECC_W-1:0]  syn_s;
    logic              pairs_ok_s;
    logic [1:0]        status_s;

    assign beat_s     = in_valid && in_ready;
    assign acc_clr_s  = (state_r == S_IDLE) && start && !abort;
    assign acc_beat_s = beat_s && (state_r == S_DATA);

    ecc_parity_acc #(
        .DATA_W       (DATA_W),
        .SECTOR_WORDS (SECTOR_WORDS)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr_s),
        .beat      (acc_beat_s),
        .data      (in_data),
        .word_idx  (word_r),
        .colacc    (colacc_s),
        .line_odd  (line_odd_s),
        .line_even (line_even_s)
    );

    // Column parity: split the accumulated column XOR by each bit-index bit.
    always_comb begin
        col_odd_s  = '0;
        col_even_s = '0;
        for (int k = 0; k < CW; k++) begin
            for (int b = 0; b < DATA_W; b++) begin
                if (b[k]) begin
                    col_odd_s[k] = col_odd_s[k] ^ colacc_s[b];
                end else begin
                    col_even_s[k] = col_even_s[k] ^ colacc_s[b];
                end
            end
        end
    end

    assign ecc_s = {line_odd_s, line_even_s, col_odd_s, col_even_s};

    // A single data-bit error flips exactly one member of every odd/even pair.
    assign pairs_ok_s = (&(syn_s[ECC_W-1 -: LW] ^ syn_s[ECC_W-LW-1 -: LW]))
                      & (&(syn_s[2*CW-1 -: CW] ^ syn_s[CW-1:0]));

    // Syndrome classification; encode always reports clean.
    always_comb begin
        syn_s    = '0;
        status_s = ST_CLEAN;
        if (mode_r) begin
            syn_s = ecc_s ^ stored_r;
            if (syn_s == '0) begin
                status_s = ST_CLEAN;
            end else if (pairs_ok_s) begin
                status_s = ST_CORR;
            end else if ($onehot(syn_s)) begin
                status_s = ST_ECCERR;
            end else begin
                status_s = ST_UNCORR;
            end
        end else begin
            syn_s    = '0;
            status_s = ST_CLEAN;
        end
    end

    // Sector FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            mode_r   <= 1'b0;
            word_r   <= '0;
            stored_r <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            ecc_out  <= '0;
            status   <= ST_CLEAN;
            err_word <= '0;
            err_bit  <= '0;
        end else if (abort && (state_r != S_IDLE)) begin
            state_r  <= S_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            ecc_out  <= '0;
            status   <= ST_CLEAN;
            err_word <= '0;
            err_bit  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state_r  <= S_DATA;
                        mode_r   <= mode;
                        word_r   <= '0;
                        stored_r <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        ecc_out  <= '0;
                        status   <= ST_CLEAN;
                        err_word <= '0;
                        err_bit  <= '0;
                    end
                end
                S_DATA: begin
                    if (beat_s) begin
                        word_r <= word_r + ONE_WORD;
                        if (word_r == LAST_WORD) begin
                            in_ready <= mode_r;
                            state_r  <= mode_r ? S_ECCIN : S_FIN;
                        end
                    end
                end
                S_ECCIN: begin
                    if (beat_s) begin
                        stored_r <= in_data[ECC_W-1:0];
                        in_ready <= 1'b0;
                        state_r  <= S_FIN;
                    end
                end
                S_FIN: begin
                    ecc_out  <= ecc_s;
                    status   <= status_s;
                    err_word <= (status_s == ST_CORR) ? syn_s[ECC_W-1 -: LW] : '0;
                    err_bit  <= (status_s == ST_CORR) ? syn_s[2*CW-1 -: CW] : '0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= S_RESULT;
                end
                S_RESULT: begin
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ECC_SECTOR_STATS_EN
    // Saturating error statistics, sampled on the done pulse; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= 16'd0;
            cnt_uncorr <= 16'd0;
        end else if (cnt_clr) begin
            cnt_corr   <= 16'd0;
            cnt_uncorr <= 16'd0;
        end else if (done) begin
            if (((status == ST_CORR) || (status == ST_ECCERR)) && (cnt_corr != 16'hFFFF)) begin
                cnt_corr <= cnt_corr + 16'd1;
            end
            if ((status == ST_UNCORR) && (cnt_uncorr != 16'hFFFF)) begin
                cnt_uncorr <= cnt_uncorr + 16'd1;
            end
        end
    end
`endif

endmodule
